// File: rtl/mem_access_unit_pkg.sv
// mem_pkg: shared funct3 codes, FSM state encoding and default memory depth for mem_access_unit
package mem_pkg;
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam int MEM_DEPTH_DEFAULT = 64;
    typedef enum logic {ST_IDLE, ST_RMW_WR} state_t;
endpackage

// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if: core request/response plus word-memory bus
// core side: req_valid, req_we, funct3, addr, wdata -> rdata, stall, access_err
// memory side: mem_addr, mem_wdata, mem_we -> mem_rdata
// master = core + memory environment, slave = mem_access_unit
interface mem_access_unit_if;
    logic        req_valid;
    logic        req_we;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        stall;
    logic        access_err;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic [31:0] mem_rdata;
    modport master (
        output req_valid, req_we, funct3, addr, wdata, mem_rdata,
        input  rdata, stall, access_err, mem_addr, mem_wdata, mem_we
    );
    modport slave (
        input  req_valid, req_we, funct3, addr, wdata, mem_rdata,
        output rdata, stall, access_err, mem_addr, mem_wdata, mem_we
    );
endinterface

// File: rtl/mem_access_unit_load_formatter.sv
// load_formatter: selects byte/halfword lane of a memory word and sign/zero-extends it
// ports: word (memory word), lane (addr[1:0]), funct3 (width/sign code) -> data (formatted result)
module load_formatter
    import mem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  lane,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);
    logic [7:0]  b;
    logic [15:0] h;
    assign b = word[{lane, 3'b000} +: 8];
    assign h = word[{lane[1], 4'b0000} +: 16];
    assign data = funct3 == F3_B  ? {{24{b[7]}}, b} :
                  funct3 == F3_BU ? {24'b0, b} :
                  funct3 == F3_H  ? {{16{h[15]}}, h} :
                  funct3 == F3_HU ? {16'b0, h} : word;
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: byte-address load/store formatter in front of a word-indexed data memory
// ports: clk, rst (sync, active-high), bus (mem_access_unit_if.slave: core request/response and memory bus)
// optional MEM_ACCESS_STATS_EN adds stat_loads, stat_stores, stat_rmw, stat_errs counters
// SB/SH run as read-merge (IDLE, stalls core) then write (RMW_WR)
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int MEM_DEPTH = MEM_DEPTH_DEFAULT,
    parameter int IDX_W     = $clog2(MEM_DEPTH)
) (
    input logic             clk,
    input logic             rst,
    mem_access_unit_if.slave bus
`ifdef MEM_ACCESS_STATS_EN
    ,
    output logic [31:0]     stat_loads,
    output logic [31:0]     stat_stores,
    output logic [31:0]     stat_rmw,
    output logic [31:0]     stat_errs
`endif
);
    state_t           state_q, state_d;
    logic [31:0]      buf_q, buf_d, merge, fmt;
    logic [IDX_W-1:0] idx_q, idx_d, idx;
    logic             f3_ok, misaligned, out_of_range, err, idle, ok, is_sub;

    assign idx  = bus.addr[IDX_W+1:2];
    assign idle = state_q == ST_IDLE;

    always_comb begin
        f3_ok        = (bus.funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU}) && !(bus.req_we && bus.funct3[2]);
        misaligned   = (bus.funct3[1:0] == 2'b01 && bus.addr[0]) || (bus.funct3 == F3_W && bus.addr[1:0] != 2'b00);
        out_of_range = bus.addr[31:2] >= 30'(MEM_DEPTH);
        err          = !f3_ok || misaligned || out_of_range;
        ok           = bus.req_valid && !err && idle;
        is_sub       = ok && bus.req_we && bus.funct3 != F3_W;
    end

    // replace only the addressed lane(s) of the word just read
    always_comb begin
        merge = bus.mem_rdata;
        if (bus.funct3[0])
            merge[{bus.addr[1], 4'b0000} +: 16] = bus.wdata[15:0];
        else
            merge[{bus.addr[1:0], 3'b000} +: 8] = bus.wdata[7:0];
    end

    load_formatter u_fmt (
        .word   (bus.mem_rdata),
        .lane   (bus.addr[1:0]),
        .funct3 (bus.funct3),
        .data   (fmt)
    );

    assign bus.rdata      = (ok && !bus.req_we) ? fmt : 32'b0;
    assign bus.access_err = bus.req_valid && err && idle && !rst;

    always_comb begin
        state_d       = state_q;
        buf_d         = buf_q;
        idx_d         = idx_q;
        bus.stall     = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = {{(32-IDX_W){1'b0}}, idx};
        bus.mem_wdata = bus.wdata;
        if (idle) begin
            bus.mem_we = ok && bus.req_we && bus.funct3 == F3_W;
            if (is_sub) begin
                bus.stall = 1'b1;
                state_d   = ST_RMW_WR;
                buf_d     = merge;
                idx_d     = idx;
            end
        end else begin
            bus.mem_addr  = {{(32-IDX_W){1'b0}}, idx_q};
            bus.mem_wdata = buf_q;
            bus.mem_we    = 1'b1;
            state_d       = ST_IDLE;
        end
        // reset aborts an in-flight write immediately, not just at the next edge
        if (rst) begin
            bus.stall  = 1'b0;
            bus.mem_we = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            buf_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            idx_q   <= idx_d;
        end
    end

`ifdef MEM_ACCESS_STATS_EN
    logic [31:0] loads_q, loads_d, stores_q, stores_d, rmw_q, rmw_d, errs_q, errs_d;

    always_comb begin
        loads_d  = loads_q + 32'(ok && !bus.req_we);
        stores_d = stores_q + 32'((ok && bus.req_we && bus.funct3 == F3_W) || !idle);
        rmw_d    = rmw_q + 32'(!idle);
        errs_d   = errs_q + 32'(bus.access_err);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            loads_q  <= '0;
            stores_q <= '0;
            rmw_q    <= '0;
            errs_q   <= '0;
        end else begin
            loads_q  <= loads_d;
            stores_q <= stores_d;
            rmw_q    <= rmw_d;
            errs_q   <= errs_d;
        end
    end

    assign stat_loads  = loads_q;
    assign stat_stores = stores_q;
    assign stat_rmw    = rmw_q;
    assign stat_errs   = errs_q;
`endif
endmodule
